// File: rtl/mem_pipe_ctrl.sv
// MEM-stage sequencing controller: data-memory handshake FSM, pipeline stall/flush
// generation, access timeout and a saturating memory-stall cycle counter.
module mem_pipe_ctrl #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemReqM,
  input  logic             MemWriteM,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_gnt,
  input  logic             dmem_rvalid,
  input  logic [31:0]      dmem_rdata,
  output logic [31:0]      ReadDataM,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_GNT  = 2'd1,
    WAIT_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    wcnt_q, wcnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic req_s, done_s, load_done_s, waiting_s, tmo_s, mem_stall_s, lwstall_s;

  // Handshake decode, completion/timeout detection and next-state computation.
  always_comb begin
    req_s       = 1'b0;
    done_s      = 1'b0;
    load_done_s = 1'b0;
    state_d     = state_q;
    wcnt_d      = '0;

    case (state_q)
      IDLE:      req_s = MemReqM;
      WAIT_GNT:  req_s = 1'b1;
      WAIT_RESP: req_s = 1'b0;
      default:   req_s = 1'b0;
    endcase

    if (req_s && dmem_gnt) begin
      if (MemWriteM) begin
        done_s = 1'b1;
      end else if (dmem_rvalid) begin
        done_s      = 1'b1;
        load_done_s = 1'b1;
      end else begin
        done_s = 1'b0;
      end
    end else if (state_q == WAIT_RESP && dmem_rvalid) begin
      done_s      = 1'b1;
      load_done_s = 1'b1;
    end else begin
      done_s = 1'b0;
    end

    waiting_s   = (state_q != IDLE);
    // A timed-out access is released as if done, but carries no data.
    tmo_s       = waiting_s && (wcnt_q == WAIT_LAST) && !done_s;
    mem_stall_s = ((state_q == IDLE && MemReqM) || waiting_s) && !done_s && !tmo_s;

    if (done_s || tmo_s) begin
      state_d = IDLE;
    end else if (state_q == WAIT_RESP) begin
      state_d = WAIT_RESP;
    end else if (req_s && dmem_gnt) begin
      state_d = WAIT_RESP;
    end else if (req_s) begin
      state_d = WAIT_GNT;
    end else begin
      state_d = IDLE;
    end

    if (waiting_s && state_d != IDLE) begin
      wcnt_d = wcnt_q + 1'b1;
    end else begin
      wcnt_d = '0;
    end

    err_d = err_q | tmo_s;

    if (mem_stall_s && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    lwstall_s = ResultSrcE0 && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));
  end

  // FSM state, wait counter, sticky timeout flag and stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced low while reset is held, independent of the inputs.
  assign dmem_req    = reset & req_s;
  assign dmem_we     = reset & req_s & MemWriteM;
  assign ReadDataM   = (reset && load_done_s) ? dmem_rdata : 32'd0;
  assign StallF      = reset & (mem_stall_s | lwstall_s);
  assign StallD      = reset & (mem_stall_s | lwstall_s);
  assign StallE      = reset & mem_stall_s;
  assign StallM      = reset & mem_stall_s;
  assign FlushW      = reset & mem_stall_s;
  assign FlushD      = reset & ~mem_stall_s & PCSrcE;
  assign FlushE      = reset & ~mem_stall_s & (PCSrcE | lwstall_s);
  assign timeout_err = reset & err_q;
  assign stall_cnt   = cnt_q;

endmodule

// File: doc/mem_pipe_ctrl.md
Name: mem_pipe_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32 core.
- Drives the data-memory request/grant/response handshake for the MEM stage.
- Generates stall and flush enables for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers from three sources: data-memory wait states, load-use hazards and taken branches.
- Includes a sticky access-timeout error and a saturating memory-stall cycle counter.

Parameters:
- TIMEOUT, 256: max cycles spent in a wait state before an access is abandoned.
- CNT_W, 32: width of the stall cycle counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- MemReqM  in  1  MEM-stage instruction accesses data memory
- MemWriteM  in  1  access is a store (valid with MemReqM)
- dmem_req  out  1  request to data memory
- dmem_we  out  1  write strobe, equals MemWriteM while dmem_req=1, else 0
- dmem_gnt  in  1  memory accepted request
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load data
- ReadDataM  out  32  load data toward the MEM/WB register
- Rs1D, Rs2D  in  5  decode-stage source registers
- RdE  in  5  execute-stage destination register
- ResultSrcE0  in  1  execute-stage instruction is a load
- PCSrcE  in  1  taken branch or jump in EX
- StallF, StallD, StallE, StallM  out  1  hold the PC and the IF/ID, ID/EX and EX/MEM registers
- FlushD, FlushE, FlushW  out  1  clear IF/ID, ID/EX and MEM/WB to a bubble
- timeout_err  out  1  sticky access timeout
- stall_cnt  out  CNT_W  memory-stall cycles, saturating

Behaviour:
- Reset: asynchronous, active-low. Clock: clk. Reset returns the FSM to IDLE, clears the timeout counter, timeout_err and stall_cnt. While reset is low, all outputs are 0.
- Reset during an outstanding access abandons it. No request is re-issued after reset.
- FSM states: IDLE, WAIT_GNT, WAIT_RESP.
- Completion (done) is evaluated combinationally each cycle. An access is done when:
  - a store is granted; or
  - a load has dmem_rvalid=1, either in the grant cycle or in WAIT_RESP.
- IDLE:
  - MemReqM=0: dmem_req=0, no memory stall.
  - MemReqM=1: dmem_req=1.
  - done in the same cycle: stay in IDLE, no stall (zero-wait memory).
  - load granted without rvalid: go to WAIT_RESP.
  - no grant: go to WAIT_GNT.
- WAIT_GNT: dmem_req=1. Completion and transition rules are the same as IDLE with MemReqM=1. On done, return to IDLE.
- WAIT_RESP: dmem_req=0 and dmem_gnt is ignored. dmem_rvalid=1 means done; return to IDLE.
- mem_stall = MemReqM & ~done in IDLE, or ~done in either wait state. MemReqM is not sampled in wait states; StallM holds the instruction.
- ReadDataM = dmem_rdata in a cycle where a load is done, else 0. dmem_rvalid with no outstanding load is ignored.
- Memory stall response: StallF=StallD=StallE=StallM=1 and FlushW=1, so a bubble enters MEM/WB and no register write repeats. FlushD=FlushE=0 during a memory stall, even when PCSrcE or a load-use hazard is present; these act once the stall releases.
- Load-use hazard: lwstall = ResultSrcE0 & (RdE≠0) & (Rs1D==RdE | Rs2D==RdE). When there is no mem_stall, lwstall gives StallF=StallD=1 and FlushE=1.
- Taken branch: when there is no mem_stall, PCSrcE gives FlushD=1 and FlushE=1. This is OR'ed with lwstall; if both are present, StallF/StallD still come from lwstall.
- All stall/flush outputs are combinational. No added latency beyond the FSM state.
- Timeout:
  - The wait counter increments every cycle the FSM is in WAIT_GNT or WAIT_RESP, and clears in IDLE.
  - When the counter equals TIMEOUT-1 and the access is not done: force done, set ReadDataM=0, set timeout_err=1 (sticky until reset), return to IDLE.
  - dmem_rvalid that arrives later is ignored.
- stall_cnt increments each cycle mem_stall=1 and saturates at all-ones.

Test Plan:
- Zero-wait load (gnt=rvalid=1 in the request cycle, rdata=0xDEADBEEF): no stall asserted, ReadDataM=0xDEADBEEF that cycle, stall_cnt stays 0.
- Load with 2-cycle grant delay, then rvalid 3 cycles after grant with rdata=0x12345678:
  - stalls and FlushW high for 5 cycles, dmem_req high for the first 3 cycles;
  - release cycle has ReadDataM=0x12345678;
  - stall_cnt=5.
- Store granted after 1 wait cycle: 1 stall cycle, dmem_we=1 while dmem_req=1, FSM returns to IDLE without waiting for rvalid.
- Load-use case (ResultSrcE0=1, RdE=5, Rs2D=5): StallF=StallD=FlushE=1, StallM=0. With RdE=0: no stall.
- PCSrcE=1 during a memory stall: FlushD/FlushE stay 0 until the grant cycle, then both are 1.
- TIMEOUT=8, no grant ever:
  - the final wait cycle (cycle 8 after the request) releases the stall with ReadDataM=0;
  - timeout_err=1 and stays 1;
  - asserting reset mid-wait clears it and the FSM returns to IDLE.
